// File: rtl/id_ex_issue_buffer.sv
// ID/EX issue buffer: a small circular queue of decoded instructions sitting
// between decode and execute. It detects load-use hazards against buffered
// loads and the load that was just issued, and keeps stall/flush statistics.
module id_ex_issue_buffer #(
    parameter int PAYLOAD_W = 128,
    parameter int DEPTH     = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 Rst,
    input  logic                 hold,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic                 in_regwrite,
    input  logic                 in_memread,
    input  logic                 in_uses_rs1,
    input  logic                 in_uses_rs2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [4:0]           out_rd,
    output logic                 out_regwrite,
    output logic                 out_memread,
    output logic                 hz,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits and
    // the occupancy count needs one extra bit to represent "full".
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W    = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Entry storage (no reset needed: occupancy masks stale contents)
    logic [PAYLOAD_W-1:0] payload_mem  [DEPTH];
    logic [4:0]           rd_mem       [DEPTH];
    logic                 regwrite_mem [DEPTH];
    logic                 memread_mem  [DEPTH];

    // Control state
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             ld_v_q, ld_v_d;
    logic [4:0]       ld_rd_q, ld_rd_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Derived handshake / hazard signals
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             rs1_hazard;
    logic             rs2_hazard;
    logic             rs1_ld_hit;
    logic             rs2_ld_hit;
    logic [DEPTH-1:0] entry_live;
    logic [DEPTH-1:0] rs1_hit_vec;
    logic [DEPTH-1:0] rs2_hit_vec;

    // Head-of-queue view
    logic [PAYLOAD_W-1:0] head_payload;
    logic [4:0]           head_rd;
    logic                 head_regwrite;
    logic                 head_memread;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // Per-entry liveness and load-use comparison. An entry is live when its
    // distance from the read pointer (mod DEPTH) is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] offset;
            assign offset          = PTR_W'(gi) - rd_ptr_q;
            assign entry_live[gi]  = ({1'b0, offset} < count_q);
            assign rs1_hit_vec[gi] = entry_live[gi] && memread_mem[gi]
                                     && (rd_mem[gi] == in_rs1);
            assign rs2_hit_vec[gi] = entry_live[gi] && memread_mem[gi]
                                     && (rd_mem[gi] == in_rs2);
        end
    endgenerate

    // The load issued last cycle has not produced data yet either.
    assign rs1_ld_hit = ld_v_q && (ld_rd_q == in_rs1);
    assign rs2_ld_hit = ld_v_q && (ld_rd_q == in_rs2);

    // x0 is hardwired, so a zero source never waits on anything.
    assign rs1_hazard = in_uses_rs1 && (in_rs1 != 5'd0) && ((|rs1_hit_vec) || rs1_ld_hit);
    assign rs2_hazard = in_uses_rs2 && (in_rs2 != 5'd0) && ((|rs2_hit_vec) || rs2_ld_hit);
    assign hz         = in_valid && (rs1_hazard || rs2_hazard);

    // Acceptance is deliberately independent of out_ready: a full buffer
    // refuses even if execute is draining it this cycle.
    assign in_ready = !hold && !flush && !hz && !full;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready && !hold && !flush;

    assign head_payload  = payload_mem[rd_ptr_q];
    assign head_rd       = rd_mem[rd_ptr_q];
    assign head_regwrite = regwrite_mem[rd_ptr_q];
    assign head_memread  = memread_mem[rd_ptr_q];

    // Present the head entry, or an all-zero bubble when nothing is buffered
    always_comb begin
        out_valid    = !empty;
        out_payload  = '0;
        out_rd       = 5'd0;
        out_regwrite = 1'b0;
        out_memread  = 1'b0;
        if (!empty) begin
            out_payload  = head_payload;
            out_rd       = head_rd;
            out_regwrite = head_regwrite;
            out_memread  = head_memread;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Next-state: flush beats hold beats normal push/pop operation
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ld_v_d      = ld_v_q;
        ld_rd_d     = ld_rd_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ld_v_d   = 1'b0;
            ld_rd_d  = 5'd0;
            if (flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end else if (!hold) begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + OCC_ONE;
                2'b01:   count_d = count_q - OCC_ONE;
                default: count_d = count_q;
            endcase

            // Track only the instruction leaving this cycle; anything older
            // has had its load data forwarded by the time it matters.
            if (pop) begin
                ld_v_d  = head_memread;
                ld_rd_d = head_rd;
            end else begin
                ld_v_d  = 1'b0;
                ld_rd_d = 5'd0;
            end

            if (hz && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (Rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ld_v_q      <= 1'b0;
            ld_rd_q     <= 5'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ld_v_q      <= ld_v_d;
            ld_rd_q     <= ld_rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Entry write on accepted push; push is already false under hold/flush
    always_ff @(posedge clk) begin
        if (!Rst && push) begin
            payload_mem[wr_ptr_q]  <= in_payload;
            rd_mem[wr_ptr_q]       <= in_rd;
            regwrite_mem[wr_ptr_q] <= in_regwrite;
            memread_mem[wr_ptr_q]  <= in_memread;
        end
    end

endmodule

// File: tb/tb_id_ex_issue_buffer.sv
// Self-checking bench for id_ex_issue_buffer: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_id_ex_issue_buffer;

    localparam int PW    = 128;
    localparam int DEPTH = 2;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          Rst, hold, flush, in_valid, in_ready;
    logic [PW-1:0] in_payload;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic          in_regwrite, in_memread, in_uses_rs1, in_uses_rs2;
    logic          out_valid, out_ready;
    logic [PW-1:0] out_payload;
    logic [4:0]    out_rd;
    logic          out_regwrite, out_memread, hz;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    id_ex_issue_buffer #(.PAYLOAD_W(PW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .Rst(Rst), .hold(hold), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_regwrite(in_regwrite), .in_memread(in_memread),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .out_rd(out_rd), .out_regwrite(out_regwrite), .out_memread(out_memread),
        .hz(hz), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [PW-1:0] payload;
        logic [4:0]    rd;
        logic          regwrite;
        logic          memread;
    } ent_t;

    ent_t q[$];
    bit   m_ld_v = 0;
    int   m_ld_rd = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    bit   model_live = 0;
    localparam int CMAX = (1 << CW) - 1;

    function automatic bit src_hit(input logic [4:0] a);
        if (a == 0) return 0;
        if (m_ld_v && m_ld_rd == int'(a)) return 1;
        foreach (q[i]) if (q[i].memread && q[i].rd == a) return 1;
        return 0;
    endfunction

    function automatic bit exp_hz();
        return in_valid && ((in_uses_rs1 && src_hit(in_rs1)) ||
                            (in_uses_rs2 && src_hit(in_rs2)));
    endfunction

    function automatic bit exp_ready();
        return !hold && !flush && !exp_hz() && (q.size() < DEPTH);
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge from the pre-edge inputs
    always @(posedge clk) begin
        if (Rst) begin
            q.delete();
            m_ld_v = 0; m_ld_rd = 0; m_stall = 0; m_flush = 0;
            model_live = 1;
        end else if (model_live) begin
            if (flush) begin
                q.delete();
                m_ld_v = 0; m_ld_rd = 0;
                if (m_flush != CMAX) m_flush++;
                $display("flush t=%0t", $time);
            end else if (!hold) begin
                bit   h, rdy, do_pop, do_push;
                ent_t e;
                h       = exp_hz();
                rdy     = exp_ready();
                do_pop  = (q.size() > 0) && out_ready;
                do_push = in_valid && rdy;
                if (h && m_stall != CMAX) m_stall++;
                if (do_pop) begin
                    m_ld_v  = q[0].memread;
                    m_ld_rd = int'(q[0].rd);
                    $display("pop  rd=%0d memread=%0b t=%0t", q[0].rd, q[0].memread, $time);
                    void'(q.pop_front());
                end else begin
                    m_ld_v = 0; m_ld_rd = 0;
                end
                if (do_push) begin
                    e.payload = in_payload; e.rd = in_rd;
                    e.regwrite = in_regwrite; e.memread = in_memread;
                    q.push_back(e);
                    $display("push rd=%0d memread=%0b t=%0t", in_rd, in_memread, $time);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_live && !Rst) begin
            if (q.size() > 0) begin
                chk("m_out_valid", out_valid, 1);
                chk("m_out_payload", out_payload, q[0].payload);
                chk("m_out_rd", out_rd, q[0].rd);
                chk("m_out_regwrite", out_regwrite, q[0].regwrite);
                chk("m_out_memread", out_memread, q[0].memread);
            end else begin
                chk("m_out_valid", out_valid, 0);
                chk("m_out_payload", out_payload, 0);
                chk("m_out_rd", out_rd, 0);
                chk("m_out_regwrite", out_regwrite, 0);
                chk("m_out_memread", out_memread, 0);
            end
            chk("m_hz", hz, exp_hz());
            chk("m_in_ready", in_ready, exp_ready());
            chk("m_stall_cnt", stall_cnt, m_stall);
            chk("m_flush_cnt", flush_cnt, m_flush);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic present(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                           input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2, input logic [PW-1:0] pl);
        in_valid = v; in_rd = rd; in_regwrite = rw; in_memread = mr;
        in_rs1 = rs1; in_uses_rs1 = u1; in_rs2 = rs2; in_uses_rs2 = u2; in_payload = pl;
    endtask

    initial begin
        Rst = 1; hold = 0; flush = 0; out_ready = 0;
        present(0, 0, 0, 0, 0, 0, 0, 0, '0);
        step(); step();
        Rst = 0;
        settle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_flush", flush_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        step();

        // Single push then pop, latency 1
        out_ready = 1;
        present(1, 5, 1, 0, 0, 0, 0, 0, 128'hA5A5);
        settle(); chk("a_in_ready", in_ready, 1);
        step();
        in_valid = 0;
        settle();
        chk("a_out_valid", out_valid, 1);
        chk("a_out_rd", out_rd, 5);
        chk("a_out_rw", out_regwrite, 1);
        chk("a_payload", out_payload, 128'hA5A5);
        step();
        settle(); chk("a_drained", out_valid, 0);

        // Fill to DEPTH, third refused, then drain with wraparound
        out_ready = 0;
        present(1, 1, 1, 0, 0, 0, 0, 0, 128'h11);
        step();
        present(1, 2, 1, 0, 0, 0, 0, 0, 128'h22);
        step();
        present(1, 3, 0, 0, 0, 0, 0, 0, 128'h33);
        settle(); chk("full_in_ready", in_ready, 0); chk("full_head", out_rd, 1);
        step();
        out_ready = 1;
        settle(); chk("full_ready_indep", in_ready, 0); chk("full_head2", out_rd, 1);
        step();
        settle(); chk("drain_b", out_rd, 2); chk("c_accept", in_ready, 1);
        step();
        in_valid = 0;
        settle(); chk("drain_c", out_rd, 3); chk("drain_c_pl", out_payload, 128'h33);
        step();
        settle(); chk("drained2", out_valid, 0);

        // Load-use against the just-popped load
        present(1, 7, 1, 1, 0, 0, 0, 0, 128'h77);
        step();
        in_valid = 0;
        settle(); chk("ld_memread", out_memread, 1); chk("ld_rd", out_rd, 7);
        step();
        present(1, 8, 1, 0, 7, 1, 0, 0, 128'h88);
        settle(); chk("lu_hz", hz, 1); chk("lu_ready", in_ready, 0);
        step();
        settle(); chk("lu_hz_clr", hz, 0); chk("lu_stall", stall_cnt, 1); chk("lu_ready2", in_ready, 1);
        step();
        in_valid = 0;
        step();

        // Load-use against a buffered load via rs2
        out_ready = 0;
        present(1, 9, 1, 1, 0, 0, 0, 0, 128'h99);
        step();
        present(1, 10, 1, 0, 0, 1, 9, 1, 128'hAA);
        settle(); chk("buf_hz", hz, 1);
        step();
        in_uses_rs2 = 0;
        settle(); chk("buf_hz_off", hz, 0); chk("buf_ready", in_ready, 1); chk("buf_stall", stall_cnt, 2);
        step();
        in_valid = 0; out_ready = 1;
        step(); step(); step();
        settle(); chk("buf_drained", out_valid, 0);

        // x0 source never hazards, even against a load to x0
        out_ready = 0;
        present(1, 0, 0, 1, 0, 0, 0, 0, 128'hB0);
        step();
        present(1, 11, 1, 0, 0, 1, 0, 0, 128'hBB);
        settle(); chk("x0_hz", hz, 0); chk("x0_ready", in_ready, 1);
        step();

        // Flush with hold and a presented instruction
        present(1, 12, 1, 0, 0, 0, 0, 0, 128'hCC);
        flush = 1; hold = 1;
        settle(); chk("fl_ready", in_ready, 0); chk("fl_pre_valid", out_valid, 1);
        step();
        flush = 0; hold = 0; in_valid = 0;
        settle(); chk("fl_empty", out_valid, 0); chk("fl_cnt", flush_cnt, 1); chk("fl_ready2", in_ready, 1);
        step();
        settle(); chk("fl_not_stored", out_valid, 0);

        // Hold freezes everything
        present(1, 13, 1, 0, 0, 0, 0, 0, 128'hDD);
        step();
        hold = 1; out_ready = 1;
        present(1, 14, 1, 0, 0, 0, 0, 0, 128'hEE);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("hold_valid", out_valid, 1);
            chk("hold_rd", out_rd, 13);
            chk("hold_ready", in_ready, 0);
            step();
        end
        hold = 0; in_valid = 0;
        settle(); chk("hold_after_rd", out_rd, 13); chk("hold_stall", stall_cnt, 2); chk("hold_flush", flush_cnt, 1);
        step();
        settle(); chk("hold_popped", out_valid, 0);

        // Reset mid-operation discards entries
        out_ready = 0;
        present(1, 15, 1, 0, 0, 0, 0, 0, 128'hF5);
        step();
        present(1, 16, 1, 0, 0, 0, 0, 0, 128'hF6);
        step();
        in_valid = 0;
        settle(); chk("mid_pre", out_valid, 1);
        Rst = 1;
        step();
        Rst = 0;
        settle(); chk("mid_valid", out_valid, 0); chk("mid_stall", stall_cnt, 0); chk("mid_flush", flush_cnt, 0);
        out_ready = 1;
        step();
        settle(); chk("mid_gone", out_valid, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
